// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory: per-cycle
// round-robin with a bounded burst lock and tagged one-cycle read return.
module dm_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int WADDR_W  = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_write,
  input  logic               m0_lock,
  input  logic [31:0]        m0_addr,
  input  logic [DATA_W-1:0]  m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_err,
  input  logic               m1_req,
  input  logic               m1_write,
  input  logic               m1_lock,
  input  logic [31:0]        m1_addr,
  input  logic [DATA_W-1:0]  m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_err,
  output logic               DM_enable,
  output logic               DM_write,
  output logic [WADDR_W-1:0] DM_address,
  output logic [DATA_W-1:0]  DM_in,
  input  logic [DATA_W-1:0]  DM_out
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  logic               last_owner;
  logic               locked_vld;
  logic               locked_owner;
  logic [CNT_W-1:0]   lock_cnt;
  logic               rd_vld_p1;
  logic               rd_id_p1;
  logic               err0_p1;
  logic               err1_p1;
  logic [WADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata0_q;
  logic [DATA_W-1:0]  rdata1_q;

  logic               ok0;
  logic               ok1;
  logic               any;
  logic               win;
  logic               lock_hold;
  logic               acc;
  logic               win_write;
  logic               win_lock;
  logic               win_ok;
  logic               other_req;
  logic [WADDR_W-1:0] win_waddr;
  logic [DATA_W-1:0]  win_wdata;
  logic               unused_addr_lsbs;

  // Byte-lane bits carry no meaning for a word-wide memory.
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  assign ok0 = (m0_addr[31:WADDR_W+2] == '0);
  assign ok1 = (m1_addr[31:WADDR_W+2] == '0);

  always_comb begin
    any       = (m0_req | m1_req) & ~rst;
    lock_hold = locked_vld && (lock_cnt < MAX_CNT);
    if (m0_req && m1_req)
      win = lock_hold ? locked_owner : ~last_owner;
    else
      win = m1_req;
    win_write = win ? m1_write : m0_write;
    win_lock  = win ? m1_lock  : m0_lock;
    win_ok    = win ? ok1      : ok0;
    other_req = win ? m0_req   : m1_req;
    win_waddr = win ? m1_addr[WADDR_W+1:2] : m0_addr[WADDR_W+1:2];
    win_wdata = win ? m1_wdata : m0_wdata;
    acc       = any & win_ok;
  end

  assign m0_gnt     = any & ~win;
  assign m1_gnt     = any & win;
  assign DM_enable  = acc;
  assign DM_write   = acc & win_write;
  // Memory bus holds its last driven value when no valid access is granted.
  assign DM_address = acc ? win_waddr : addr_q;
  assign DM_in      = acc ? win_wdata : wdata_q;

  assign m0_rvalid  = rd_vld_p1 & ~rd_id_p1;
  assign m1_rvalid  = rd_vld_p1 & rd_id_p1;
  assign m0_rdata   = m0_rvalid ? DM_out : rdata0_q;
  assign m1_rdata   = m1_rvalid ? DM_out : rdata1_q;
  assign m0_err     = err0_p1;
  assign m1_err     = err1_p1;

  // Stage p0 -> p1: grant bookkeeping, read tag and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner   <= 1'b1;
      locked_vld   <= 1'b0;
      locked_owner <= 1'b0;
      lock_cnt     <= '0;
      rd_vld_p1    <= 1'b0;
      rd_id_p1     <= 1'b0;
      err0_p1      <= 1'b0;
      err1_p1      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      err0_p1   <= m0_gnt & ~ok0;
      err1_p1   <= m1_gnt & ~ok1;
      rd_vld_p1 <= acc & ~win_write;
      rd_id_p1  <= win;
      if (m0_rvalid) rdata0_q <= DM_out;
      if (m1_rvalid) rdata1_q <= DM_out;
      if (acc) begin
        addr_q  <= win_waddr;
        wdata_q <= win_wdata;
      end
      if (any) last_owner <= win;
      // The count tracks grants handed out while the other master waits.
      if (any && win_lock) begin
        locked_vld   <= 1'b1;
        locked_owner <= win;
        if (!other_req)
          lock_cnt <= '0;
        else if (locked_vld && (locked_owner == win))
          lock_cnt <= lock_cnt + CNT_W'(1);
        else
          lock_cnt <= CNT_W'(1);
      end else begin
        locked_vld <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural data memory.
module tb_dm_port_arbiter;

  localparam int DATA_W   = 32;
  localparam int WADDR_W  = 16;
  localparam int MAX_LOCK = 8;

  logic               clk;
  logic               rst;
  logic               m0_req, m0_write, m0_lock;
  logic [31:0]        m0_addr;
  logic [DATA_W-1:0]  m0_wdata;
  logic               m0_gnt, m0_rvalid, m0_err;
  logic [DATA_W-1:0]  m0_rdata;
  logic               m1_req, m1_write, m1_lock;
  logic [31:0]        m1_addr;
  logic [DATA_W-1:0]  m1_wdata;
  logic               m1_gnt, m1_rvalid, m1_err;
  logic [DATA_W-1:0]  m1_rdata;
  logic               DM_enable, DM_write;
  logic [WADDR_W-1:0] DM_address;
  logic [DATA_W-1:0]  DM_in;
  logic [DATA_W-1:0]  DM_out;

  logic [DATA_W-1:0]  mem [0:15];
  int n_checks;
  int n_fail;

  dm_port_arbiter #(.DATA_W(DATA_W), .WADDR_W(WADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
    .DM_in(DM_in), .DM_out(DM_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (DM_enable) begin
      if (DM_write) mem[DM_address[3:0]] <= DM_in;
      else          DM_out <= mem[DM_address[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    DM_out   = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    rst = 1'b1;
    m0_req = 1'b1; m0_write = 1'b0; m0_lock = 1'b0; m0_addr = 32'h0; m0_wdata = '0;
    m1_req = 1'b1; m1_write = 1'b0; m1_lock = 1'b0; m1_addr = 32'h8; m1_wdata = '0;

    #3;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_dm_en", DM_enable, 0);
    check("rst_dm_addr", DM_address, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m0_err", m0_err, 0);

    cyc(); rst = 1'b0; #3;
    check("first_m0_gnt", m0_gnt, 1);
    check("first_m1_gnt", m1_gnt, 0);
    check("first_dm_addr", DM_address, 0);

    cyc(); m0_req = 1'b0; #3;
    check("m1_solo_gnt", m1_gnt, 1);
    check("m1_solo_addr", DM_address, 2);
    check("m0_rv0", m0_rvalid, 1);
    check("m0_rd0", m0_rdata, 32'hA000_0000);
    check("m1_rv_idle", m1_rvalid, 0);

    cyc(); m1_req = 1'b0; #3;
    check("idle_dm_en", DM_enable, 0);
    check("idle_addr_hold", DM_address, 2);
    check("m1_rv0", m1_rvalid, 1);
    check("m1_rd0", m1_rdata, 32'hA000_0002);
    check("m0_rd_hold", m0_rdata, 32'hA000_0000);

    cyc(); m0_req = 1'b1; m0_write = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h6; #3;
    check("wr_gnt", m0_gnt, 1);
    check("wr_dm_write", DM_write, 1);
    check("wr_dm_addr", DM_address, 4);
    check("wr_dm_in", DM_in, 32'h6);

    cyc(); m0_write = 1'b0; #3;
    check("rd_dm_addr", DM_address, 4);
    check("rd_dm_write", DM_write, 0);
    check("wr_no_rvalid", m0_rvalid, 0);

    cyc(); m0_req = 1'b0; #3;
    check("rd_rvalid", m0_rvalid, 1);
    check("rd_rdata", m0_rdata, 32'h6);
    check("rd_m1_rvalid", m1_rvalid, 0);

    // last owner is m0, so the alternating run opens with m1
    cyc(); m0_req = 1'b1; m0_addr = 32'h20; m1_req = 1'b1; m1_addr = 32'h24;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      #3;
      check("rr_m1_gnt", m1_gnt, (k % 2 == 0) ? 1 : 0);
      check("rr_m0_gnt", m0_gnt, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) begin
        check("rr_m1_rvalid", m1_rvalid, 1);
        check("rr_m1_rdata", m1_rdata, 32'hA000_0009);
        check("rr_m0_rvalid", m0_rvalid, 0);
      end else if (k > 0) begin
        check("rr_m0_rvalid", m0_rvalid, 1);
        check("rr_m0_rdata", m0_rdata, 32'hA000_0008);
        check("rr_m1_rvalid", m1_rvalid, 0);
      end
    end
    cyc(); m0_req = 1'b0; m1_req = 1'b0; #3;
    check("rr_last_rvalid", m0_rvalid, 1);
    check("rr_last_rdata", m0_rdata, 32'hA000_0008);

    cyc(); m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h30; #3;
    check("lk_pre0", m1_gnt, 1);
    cyc(); #3;
    check("lk_pre1", m1_gnt, 1);
    cyc(); m0_req = 1'b1; m0_addr = 32'h34;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      #3;
      check("lk_m1_gnt", m1_gnt, (k != 8) ? 1 : 0);
      check("lk_m0_gnt", m0_gnt, (k == 8) ? 1 : 0);
    end
    cyc(); m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; #3;
    check("lk_idle_en", DM_enable, 0);

    cyc(); m0_req = 1'b1; m0_addr = 32'h0004_0000; #3;
    check("oor_gnt", m0_gnt, 1);
    check("oor_dm_en", DM_enable, 0);
    check("oor_err_early", m0_err, 0);
    cyc(); m0_req = 1'b0; #3;
    check("oor_err", m0_err, 1);
    check("oor_rvalid", m0_rvalid, 0);
    cyc(); #3;
    check("oor_err_clr", m0_err, 0);
    check("oor_rvalid2", m0_rvalid, 0);

    cyc(); m1_req = 1'b1; m1_addr = 32'h8; #3;
    check("mr_m1_gnt", m1_gnt, 1);
    check("mr_dm_en", DM_enable, 1);
    cyc(); rst = 1'b1; #1;
    check("mr_m1_rvalid", m1_rvalid, 0);
    check("mr_m1_rdata", m1_rdata, 0);
    check("mr_m0_rdata", m0_rdata, 0);
    check("mr_m1_gnt", m1_gnt, 0);
    check("mr_dm_en", DM_enable, 0);
    check("mr_dm_addr", DM_address, 0);
    m1_req = 1'b0;
    cyc(); rst = 1'b0; #3;
    check("mr_post_rvalid", m1_rvalid, 0);
    check("mr_post_err", m1_err, 0);
    cyc(); #3;
    check("mr_post_rvalid2", m1_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
